// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller.
//   lane_state_t  : per-lane barrier FSM state
//   OPEN_MIN_DEF  : default first minute of the day entry is allowed (08:00)
//   CLOSE_MIN_DEF : default first minute of the day entry is refused again (20:00)
//   CNT_W         : width of the per-lane pass-timeout counter
package parking_pkg;

    localparam int unsigned OPEN_MIN_DEF  = 480;
    localparam int unsigned CLOSE_MIN_DEF = 1200;
    localparam int unsigned CNT_W         = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        DENY  = 3'd2,
        OPEN  = 3'd3,
        CLOSE = 3'd4
    } lane_state_t;

endpackage

// File: rtl/parking_lane.sv
// One barrier lane: request handshake, grant check, open window with
// pass-timeout, and close/re-arm. The grant decision comes from outside.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   i_req           : car present on the loop
//   i_is_uni        : badge class, latched when the request is accepted
//   i_pass          : car has driven through the barrier
//   i_grant         : grant decision, sampled in CHECK only
//   o_open          : registered barrier drive, 1 only in OPEN
//   o_event_c       : one-cycle pass event (combinational from state + pass)
//   o_timeout_c     : one-cycle timeout pulse (combinational from state + counter)
//   o_denied        : registered pulse on the first DENY cycle
//   o_cls           : latched class, stable from CHECK until the next request
module parking_lane
    import parking_pkg::*;
#(
    parameter int unsigned PASS_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic i_is_uni,
    input  logic i_pass,
    input  logic i_grant,
    output logic o_open,
    output logic o_event_c,
    output logic o_timeout_c,
    output logic o_denied,
    output logic o_cls
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PASS_TIMEOUT - 1);

    lane_state_t      r_state;
    lane_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cls;
    logic             r_open;
    logic             r_denied;
    logic             w_event;
    logic             w_timeout;

    // State, counter, class latch and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_cls    <= 1'b0;
            r_open   <= 1'b0;
            r_denied <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_open   <= (w_next == OPEN);
            r_denied <= (r_state == CHECK) && !i_grant;
            if (r_state == IDLE && i_req) begin
                r_cnt <= '0;
                r_cls <= i_is_uni;
            end else if (r_state == OPEN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and event/timeout decode; pass beats timeout
    always_comb begin
        w_next    = r_state;
        w_event   = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  if (i_req) w_next = CHECK;
            CHECK: w_next = i_grant ? OPEN : DENY;
            DENY:  if (!i_req) w_next = IDLE;
            OPEN: begin
                if (i_pass) begin
                    w_event = 1'b1;
                    w_next  = CLOSE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = CLOSE;
                end
            end
            // Hold until the loop and pass sensor clear so one car yields one event
            CLOSE: if (!i_req && !i_pass) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_open      = r_open;
    assign o_event_c   = w_event;
    assign o_timeout_c = w_timeout;
    assign o_denied    = r_denied;
    assign o_cls       = r_cls;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: independent entry and exit barrier lanes.
// Entry is granted inside opening hours when a suitable space is free;
// exit is always granted.
// Ports:
//   clk, rst_n                             : clock, async active-low reset
//   timer[31:0]                            : minute of day
//   arr_req, arr_is_uni, entry_pass        : entry loop, class, pass sensor
//   dep_req, dep_is_uni, exit_pass         : exit loop, class, pass sensor
//   uni_is_vacated_space, is_vacated_space : vacancy flags
//   entry_open, exit_open                  : barrier drives
//   car_entered/is_uni_car_entered         : entry event and class
//   car_exited/is_uni_car_exited           : exit event and class
//   entry_denied, entry_timeout, exit_timeout : status pulses
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int unsigned PASS_TIMEOUT = 16,
    parameter int unsigned OPEN_MIN     = OPEN_MIN_DEF,
    parameter int unsigned CLOSE_MIN    = CLOSE_MIN_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] timer,
    input  logic        arr_req,
    input  logic        arr_is_uni,
    input  logic        dep_req,
    input  logic        dep_is_uni,
    input  logic        entry_pass,
    input  logic        exit_pass,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        entry_open,
    output logic        exit_open,
    output logic        car_entered,
    output logic        is_uni_car_entered,
    output logic        car_exited,
    output logic        is_uni_car_exited,
    output logic        entry_denied,
    output logic        entry_timeout,
    output logic        exit_timeout
);

    logic w_in_hours;
    logic w_entry_cls;
    logic w_entry_grant;
    logic w_exit_denied_unused;

    // A uni car may use a uni space or any general space; others need a general space
    assign w_in_hours    = (timer >= 32'(OPEN_MIN)) && (timer < 32'(CLOSE_MIN));
    assign w_entry_grant = w_in_hours &&
                           ((w_entry_cls && uni_is_vacated_space) || is_vacated_space);

    parking_lane #(
        .PASS_TIMEOUT (PASS_TIMEOUT)
    ) u_entry_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (arr_req),
        .i_is_uni    (arr_is_uni),
        .i_pass      (entry_pass),
        .i_grant     (w_entry_grant),
        .o_open      (entry_open),
        .o_event_c   (car_entered),
        .o_timeout_c (entry_timeout),
        .o_denied    (entry_denied),
        .o_cls       (w_entry_cls)
    );

    parking_lane #(
        .PASS_TIMEOUT (PASS_TIMEOUT)
    ) u_exit_lane (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (dep_req),
        .i_is_uni    (dep_is_uni),
        .i_pass      (exit_pass),
        .i_grant     (1'b1),
        .o_open      (exit_open),
        .o_event_c   (car_exited),
        .o_timeout_c (exit_timeout),
        .o_denied    (w_exit_denied_unused),
        .o_cls       (is_uni_car_exited)
    );

    assign is_uni_car_entered = w_entry_cls;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_parking_gate_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] timer;
    logic        arr_req, arr_is_uni, dep_req, dep_is_uni;
    logic        entry_pass, exit_pass;
    logic        uni_is_vacated_space, is_vacated_space;
    logic        entry_open, exit_open;
    logic        car_entered, is_uni_car_entered;
    logic        car_exited, is_uni_car_exited;
    logic        entry_denied, entry_timeout, exit_timeout;

    int checks = 0;
    int errors = 0;

    parking_gate_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .timer                (timer),
        .arr_req              (arr_req),
        .arr_is_uni           (arr_is_uni),
        .dep_req              (dep_req),
        .dep_is_uni           (dep_is_uni),
        .entry_pass           (entry_pass),
        .exit_pass            (exit_pass),
        .uni_is_vacated_space (uni_is_vacated_space),
        .is_vacated_space     (is_vacated_space),
        .entry_open           (entry_open),
        .exit_open            (exit_open),
        .car_entered          (car_entered),
        .is_uni_car_entered   (is_uni_car_entered),
        .car_exited           (car_exited),
        .is_uni_car_exited    (is_uni_car_exited),
        .entry_denied         (entry_denied),
        .entry_timeout        (entry_timeout),
        .exit_timeout         (exit_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " entry_open"},    entry_open,         1'b0);
        chk({tag, " exit_open"},     exit_open,          1'b0);
        chk({tag, " car_entered"},   car_entered,        1'b0);
        chk({tag, " uni_entered"},   is_uni_car_entered, 1'b0);
        chk({tag, " car_exited"},    car_exited,         1'b0);
        chk({tag, " uni_exited"},    is_uni_car_exited,  1'b0);
        chk({tag, " entry_denied"},  entry_denied,       1'b0);
        chk({tag, " entry_timeout"}, entry_timeout,      1'b0);
        chk({tag, " exit_timeout"},  exit_timeout,       1'b0);
    endtask

    // One entry request from IDLE; g = expected grant. Returns the lane to IDLE.
    task automatic entry_attempt(input string tag, input int t, input logic uni,
                                 input logic uv, input logic v, input logic g);
        timer                = 32'(t);
        arr_is_uni           = uni;
        uni_is_vacated_space = uv;
        is_vacated_space     = v;
        arr_req              = 1'b1;
        @(negedge clk);                       // CHECK
        chk({tag, " open in CHECK"}, entry_open, 1'b0);
        @(negedge clk);                       // OPEN or first DENY cycle
        chk({tag, " open"},   entry_open,   g);
        chk({tag, " denied"}, entry_denied, ~g);
        if (g) begin
            entry_pass = 1'b1;
            #1;
            chk({tag, " car_entered"}, car_entered,        1'b1);
            chk({tag, " class"},       is_uni_car_entered, uni);
            @(negedge clk);                   // CLOSE
            entry_pass = 1'b0;
            chk({tag, " open after pass"}, entry_open,  1'b0);
            chk({tag, " single event"},    car_entered, 1'b0);
        end else begin
            @(negedge clk);                   // still DENY
            chk({tag, " denied one cycle"}, entry_denied, 1'b0);
            chk({tag, " open stays 0"},     entry_open,   1'b0);
        end
        arr_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        timer = 32'd600;
        arr_req = 1'b0; arr_is_uni = 1'b0; dep_req = 1'b0; dep_is_uni = 1'b0;
        entry_pass = 1'b0; exit_pass = 1'b0;
        uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Uni car, uni vacancy; detailed latency check
        timer = 32'd600; arr_is_uni = 1'b1; uni_is_vacated_space = 1'b1;
        is_vacated_space = 1'b0; arr_req = 1'b1;
        @(negedge clk);
        chk("uni lat1 open", entry_open, 1'b0);
        chk("uni lat1 class", is_uni_car_entered, 1'b1);
        @(negedge clk);
        chk("uni lat2 open", entry_open, 1'b1);
        chk("uni no early event", car_entered, 1'b0);
        entry_pass = 1'b1; #1;
        chk("uni car_entered", car_entered, 1'b1);
        chk("uni class during", is_uni_car_entered, 1'b1);
        @(negedge clk);
        entry_pass = 1'b0;
        chk("uni event 1 cycle", car_entered, 1'b0);
        chk("uni closed", entry_open, 1'b0);
        chk("uni class after", is_uni_car_entered, 1'b1);
        arr_req = 1'b0;
        repeat (2) @(negedge clk);

        // Vacancy / class combinations
        entry_attempt("uni general", 600, 1'b1, 1'b0, 1'b1, 1'b1);
        entry_attempt("uni none",    600, 1'b1, 1'b0, 1'b0, 1'b0);
        entry_attempt("gen uni only", 600, 1'b0, 1'b1, 1'b0, 1'b0);
        entry_attempt("gen general", 600, 1'b0, 1'b0, 1'b1, 1'b1);

        // Opening-hours boundaries
        entry_attempt("t479",  479,  1'b0, 1'b1, 1'b1, 1'b0);
        entry_attempt("t480",  480,  1'b0, 1'b1, 1'b1, 1'b1);
        entry_attempt("t1199", 1199, 1'b0, 1'b1, 1'b1, 1'b1);
        entry_attempt("t1200", 1200, 1'b0, 1'b1, 1'b1, 1'b0);
        entry_attempt("t1250", 1250, 1'b1, 1'b1, 1'b1, 1'b0);

        // Exit after hours
        timer = 32'd1250; dep_is_uni = 1'b0; dep_req = 1'b1;
        @(negedge clk);
        chk("exit lat1 open", exit_open, 1'b0);
        @(negedge clk);
        chk("exit open 1250", exit_open, 1'b1);
        exit_pass = 1'b1; #1;
        chk("exit car_exited", car_exited, 1'b1);
        chk("exit class", is_uni_car_exited, 1'b0);
        @(negedge clk);
        exit_pass = 1'b0;
        chk("exit closed", exit_open, 1'b0);
        chk("exit event 1 cycle", car_exited, 1'b0);
        dep_req = 1'b0;
        repeat (2) @(negedge clk);

        // Entry timeout: 16th OPEN cycle
        timer = 32'd600; arr_is_uni = 1'b0; is_vacated_space = 1'b1; arr_req = 1'b1;
        repeat (2) @(negedge clk);            // OPEN cycle 1
        chk("to open", entry_open, 1'b1);
        repeat (14) @(negedge clk);           // OPEN cycle 15
        chk("to cycle15 no timeout", entry_timeout, 1'b0);
        chk("to cycle15 open", entry_open, 1'b1);
        timer = 32'd1300;                     // must not revoke the grant
        @(negedge clk);                       // OPEN cycle 16
        #1;
        chk("to timeout pulse", entry_timeout, 1'b1);
        chk("to no event", car_entered, 1'b0);
        chk("to still open", entry_open, 1'b1);
        @(negedge clk);
        chk("to closed next", entry_open, 1'b0);
        chk("to pulse 1 cycle", entry_timeout, 1'b0);
        arr_req = 1'b0;
        repeat (2) @(negedge clk);

        // Pass coinciding with the timeout cycle: event wins
        timer = 32'd600; arr_req = 1'b1;
        repeat (2) @(negedge clk);
        repeat (15) @(negedge clk);           // OPEN cycle 16
        entry_pass = 1'b1; #1;
        chk("coinc event", car_entered, 1'b1);
        chk("coinc no timeout", entry_timeout, 1'b0);
        @(negedge clk);
        entry_pass = 1'b0; arr_req = 1'b0;
        repeat (2) @(negedge clk);

        // Simultaneous entry and exit, arr_req held after pass
        timer = 32'd600; arr_is_uni = 1'b0; dep_is_uni = 1'b1; is_vacated_space = 1'b1;
        arr_req = 1'b1; dep_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("both entry_open", entry_open, 1'b1);
        chk("both exit_open",  exit_open,  1'b1);
        entry_pass = 1'b1; exit_pass = 1'b1; #1;
        chk("both car_entered", car_entered, 1'b1);
        chk("both car_exited",  car_exited,  1'b1);
        chk("both uni exited",  is_uni_car_exited, 1'b1);
        chk("both uni entered", is_uni_car_entered, 1'b0);
        @(negedge clk);
        entry_pass = 1'b0; exit_pass = 1'b0; dep_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held req no 2nd event", car_entered, 1'b0);
            chk("held req barrier down", entry_open, 1'b0);
        end
        arr_req = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of OPEN
        arr_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst pre open", entry_open, 1'b1);
        #2;
        rst_n = 1'b0; entry_pass = 1'b1;
        #1;
        chk("rst drops barrier", entry_open, 1'b0);
        chk("rst no event", car_entered, 1'b0);
        @(negedge clk);
        entry_pass = 1'b0; arr_req = 1'b0;
        chk_all_zero("rst held");
        rst_n = 1'b1;
        @(negedge clk);
        entry_attempt("post rst", 700, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
